// File: rtl/qos_feistel_pkg.sv
// qos_feistel_pkg: shared types, constants and round primitives for the QuantoniumOS Feistel cipher
package qos_feistel_pkg;
  typedef logic [63:0] half_t;
  typedef logic [127:0] block_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam half_t ROUND_CONST = 64'h9E3779B97F4A7C15;
  // A shift by 64 yields zero, so n = 0 returns x unchanged.
  function automatic half_t rotl64(input half_t x, input logic [5:0] n);
    return (x << n) | (x >> (7'd64 - {1'b0, n}));
  endfunction
  function automatic half_t round_key(input logic [255:0] key, input logic [5:0] i);
    return rotl64(key[{i[1:0], 6'b0} +: 64], i) ^ {58'b0, i};
  endfunction
  function automatic half_t round_f(input half_t x, input half_t k);
    return rotl64((x ^ k) + ROUND_CONST, 6'd17);
  endfunction
endpackage

// File: rtl/qos_feistel_decrypt_core_round.sv
// qos_feistel_round: one combinational Feistel round, encrypt (i_dir=0) or decrypt (i_dir=1)
// Ports: i_l/i_r current halves, i_rk round key, i_dir direction, o_l/o_r next halves.
module qos_feistel_round
  import qos_feistel_pkg::*;
(
  input  half_t i_l,
  input  half_t i_r,
  input  half_t i_rk,
  input  logic  i_dir,
  output half_t o_l,
  output half_t o_r
);
  half_t w_y;
  // Decrypt feeds L through F and rebuilds L from R; encrypt is the mirror image.
  assign w_y = (i_dir ? i_r : i_l) ^ round_f(i_dir ? i_l : i_r, i_rk);
  assign o_l = i_dir ? w_y : i_r;
  assign o_r = i_dir ? i_l : w_y;
endmodule

// File: rtl/qos_feistel_decrypt_core.sv
// qos_feistel_decrypt_core: iterative Feistel decrypt/encrypt engine with start/done job handshake
// Ports: clk, reset_n (async active-low), start, dir (0 enc / 1 dec), master_key[255:0],
//        data_in[127:0], data_out[127:0], done (1-cycle pulse), busy, round_count[5:0];
//        abort only when QOS_FEISTEL_ABORT_EN is defined.
module qos_feistel_decrypt_core
  import qos_feistel_pkg::*;
#(
  parameter int ROUNDS = 48
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef QOS_FEISTEL_ABORT_EN
  input  logic         abort,
`endif
  input  logic         start,
  input  logic         dir,
  input  logic [255:0] master_key,
  input  block_t       data_in,
  output block_t       data_out,
  output logic         done,
  output logic         busy,
  output logic [5:0]   round_count
);
  state_t       r_state, w_next;
  logic         r_dir, r_done, r_busy;
  logic [255:0] r_key;
  block_t       r_blk, r_data_out;
  logic [5:0]   r_cnt, w_idx;
  half_t        w_l, w_r;
  logic         w_last, w_abort;
`ifdef QOS_FEISTEL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  // Decrypt walks the key schedule backwards.
  assign w_idx  = r_dir ? 6'(ROUNDS - 1) - r_cnt : r_cnt;
  assign w_last = r_cnt == 6'(ROUNDS - 1);
  qos_feistel_round u_round (
    .i_l  (r_blk[127:64]),
    .i_r  (r_blk[63:0]),
    .i_rk (round_key(r_key, w_idx)),
    .i_dir(r_dir),
    .o_l  (w_l),
    .o_r  (w_r)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_abort ? IDLE : w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_key      <= '0;
      r_blk      <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next != IDLE;
      r_done  <= w_next == DONE;
      if (r_state == IDLE && start) begin
        r_dir <= dir;
        r_key <= master_key;
        r_blk <= data_in;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_blk <= {w_l, w_r};
        r_cnt <= w_abort ? 6'd0 : r_cnt + 6'd1;
        if (w_last && !w_abort) r_data_out <= {w_l, w_r};
      end
    end
  end
  assign data_out    = r_data_out;
  assign done        = r_done;
  assign busy        = r_busy;
  assign round_count = r_cnt;
endmodule

// File: tb/tb_qos_feistel_decrypt_core.sv
// tb_qos_feistel_decrypt_core: randomized self-checking bench against a loop-based cipher model
module tb_qos_feistel_decrypt_core;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [255:0] master_key = '0;
  logic [127:0] data_in = '0;
  logic [127:0] data_out;
  logic         done, busy;
  logic [5:0]   round_count;
`ifdef QOS_FEISTEL_ABORT_EN
  logic         abort = 1'b0;
`endif
  int n_checks = 0;
  int n_errors = 0;
  localparam logic [63:0] C = 64'h9E3779B97F4A7C15;
  localparam logic [255:0] KEY_V = 256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
  localparam logic [127:0] PT_V = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  qos_feistel_decrypt_core dut (
    .clk(clk), .reset_n(reset_n),
`ifdef QOS_FEISTEL_ABORT_EN
    .abort(abort),
`endif
    .start(start), .dir(dir), .master_key(master_key), .data_in(data_in),
    .data_out(data_out), .done(done), .busy(busy), .round_count(round_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_rotl(input logic [63:0] x, input int n);
    int s = n % 64;
    return s == 0 ? x : (x << s) | (x >> (64 - s));
  endfunction

  function automatic logic [63:0] m_rk(input logic [255:0] key, input int i);
    logic [63:0] k = key[64 * (i % 4) +: 64];
    return m_rotl(k, i) ^ 64'(i);
  endfunction

  function automatic logic [63:0] m_f(input logic [63:0] x, input logic [63:0] k);
    return m_rotl((x ^ k) + C, 17);
  endfunction

  function automatic logic [127:0] m_cipher(input logic d, input logic [255:0] key, input logic [127:0] blk);
    logic [63:0] l = blk[127:64];
    logic [63:0] r = blk[63:0];
    logic [63:0] t;
    for (int i = 0; i < 48; i++) begin
      if (!d) begin
        t = l ^ m_f(r, m_rk(key, i));
        l = r;
        r = t;
      end else begin
        t = r ^ m_f(l, m_rk(key, 47 - i));
        r = l;
        l = t;
      end
    end
    return {l, r};
  endfunction

  // Enters at a negedge with the core idle; leaves at the negedge where done is high.
  // Job inputs are scrambled every cycle after acceptance; start is re-pulsed at cycle glitch.
  task automatic run_job(input logic d, input logic [255:0] k, input logic [127:0] din,
                         input int glitch, input bit chk_hold, input logic [127:0] hold,
                         output int lat);
    dir = d; master_key = k; data_in = din; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      if (chk_hold && (lat == 1 || lat == 47)) check("hold", data_out, hold);
      dir = 1'($urandom);
      master_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      data_in = {$urandom, $urandom, $urandom, $urandom};
      start = (lat == glitch);
      @(posedge clk); lat++; @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, n_done;
    logic [127:0] ct, exp, prev, pt;
    logic [255:0] k;
    logic d;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_done", 128'(done), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_round_count", 128'(round_count), 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_job(1'b0, KEY_V, PT_V, -1, 1'b0, '0, lat);
    ct = data_out;
    check("enc_lat", 128'(lat), 48);
    check("enc_vec", ct, m_cipher(1'b0, KEY_V, PT_V));
    @(negedge clk);
    run_job(1'b1, KEY_V, ct, -1, 1'b0, '0, lat);
    check("dec_lat", 128'(lat), 48);
    check("dec_vec", data_out, PT_V);
    @(negedge clk);

    run_job(1'b0, '0, '0, -1, 1'b0, '0, lat);
    check("zero_vec", data_out, m_cipher(1'b0, '0, '0));
    check("zero_rc", 128'(round_count), 48);
    check("zero_busy_at_done", 128'(busy), 1);
    @(negedge clk);
    check("busy_falls", 128'(busy), 0);
    check("done_falls", 128'(done), 0);

    k = {8{32'hA5A5_1234}};
    run_job(1'b1, k, {4{32'h0BAD_F00D}}, 10, 1'b0, '0, lat);
    check("busy_start_lat", 128'(lat), 48);
    check("busy_start_res", data_out, m_cipher(1'b1, k, {4{32'h0BAD_F00D}}));
    prev = data_out;
    n_done = 0;
    repeat (55) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("busy_start_no_trace", 128'(n_done) + 128'(busy), 0);
    check("busy_start_held", data_out, prev);

    dir = 1'b0; master_key = KEY_V; data_in = PT_V; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rc", 128'(round_count), 20);
    reset_n = 1'b0;
    #1;
    check("mrst_done", 128'(done), 0);
    check("mrst_busy", 128'(busy), 0);
    check("mrst_rc", 128'(round_count), 0);
    check("mrst_data_out", data_out, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_job(1'b0, KEY_V, PT_V, -1, 1'b0, '0, lat);
    check("post_rst_lat", 128'(lat), 48);
    check("post_rst_res", data_out, ct);

    prev = data_out;
    start = 1'b1; data_in = ~PT_V;
    @(negedge clk);
    k = {8{$urandom}};
    pt = {4{$urandom}};
    run_job(1'b1, k, pt, -1, 1'b1, prev, lat);
    check("b2b_lat", 128'(lat), 48);
    check("b2b_res", data_out, m_cipher(1'b1, k, pt));
    @(negedge clk);

`ifdef QOS_FEISTEL_ABORT_EN
    prev = data_out;
    dir = 1'b0; master_key = KEY_V; data_in = ~PT_V; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 128'(busy), 0);
    check("abort_rc", 128'(round_count), 0);
    n_done = 0;
    repeat (60) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", 128'(n_done), 0);
    check("abort_data_out", data_out, prev);
    run_job(1'b0, KEY_V, PT_V, -1, 1'b0, '0, lat);
    check("abort_next", data_out, ct);
    @(negedge clk);
`endif

    for (int j = 0; j < 8; j++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      d = 1'($urandom);
      exp = m_cipher(d, k, pt);
      run_job(d, k, pt, int'($urandom_range(0, 60)), 1'b0, '0, lat);
      check("rnd_lat", 128'(lat), 48);
      check("rnd_res", data_out, exp);
      @(negedge clk);
      run_job(~d, k, exp, -1, 1'b0, '0, lat);
      check("rnd_round_trip", data_out, pt);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
